// File: rtl/swan128k256_stream_ctrl_if.sv
// Host and cipher-core signal bundle for swan128k256_stream_ctrl.
// slave is the controller's view; master is the host plus both cores.
interface swan128k256_stream_ctrl_if #(
   parameter int BLOCK_SIZE = 128,
   parameter int KEY_SIZE   = 256
);
   logic [KEY_SIZE-1:0]   key_in;
   logic                  key_load;
   logic                  in_valid;
   logic                  in_ready;
   logic [BLOCK_SIZE-1:0] in_data;
   logic                  in_mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [BLOCK_SIZE-1:0] out_data;
   logic                  out_mode;
   logic                  err_timeout;
   logic [15:0]           done_cnt;
   logic [KEY_SIZE-1:0]   core_key;
   logic [BLOCK_SIZE-1:0] core_inp;
   logic                  enc_start;
   logic                  dec_start;
   logic                  enc_ready;
   logic                  dec_ready;
   logic [BLOCK_SIZE-1:0] enc_out;
   logic [BLOCK_SIZE-1:0] dec_out;

   modport slave (
      input  key_in, key_load, in_valid, in_data, in_mode, out_ready,
             enc_ready, dec_ready, enc_out, dec_out,
      output in_ready, out_valid, out_data, out_mode, err_timeout, done_cnt,
             core_key, core_inp, enc_start, dec_start
   );

   modport master (
      output key_in, key_load, in_valid, in_data, in_mode, out_ready,
             enc_ready, dec_ready, enc_out, dec_out,
      input  in_ready, out_valid, out_data, out_mode, err_timeout, done_cnt,
             core_key, core_inp, enc_start, dec_start
   );
endinterface

// File: rtl/swan128k256_stream_ctrl.sv
// Holds the key and runs one block at a time through the ENC or DEC core; accept-to-out_valid is 2 + core latency.
// in_ready is low from acceptance until the cycle after the out_valid/out_ready handshake; a watchdog aborts a stuck core.
module swan128k256_stream_ctrl #(
   parameter int BLOCK_SIZE = 128,
   parameter int KEY_SIZE   = 256,
   parameter int TIMEOUT    = 1023
) (
   input  logic                     clk,
   input  logic                     rst,
   swan128k256_stream_ctrl_if.slave bus
);
   localparam int             CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [KEY_SIZE-1:0]   key_q, key_d;
   logic [BLOCK_SIZE-1:0] inp_q, inp_d;
   logic                  mode_q, mode_d;
   logic [BLOCK_SIZE-1:0] out_data_q, out_data_d;
   logic                  out_mode_q, out_mode_d;
   logic                  out_valid_q, out_valid_d;
   logic                  in_ready_q, in_ready_d;
   logic                  err_q, err_d;
   logic [15:0]           done_q, done_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  enc_start_q, enc_start_d;
   logic                  dec_start_q, dec_start_d;

   logic                  sel_ready;
   logic [BLOCK_SIZE-1:0] sel_out;

   // Only the core matching the latched mode is listened to.
   assign sel_ready = mode_q ? bus.dec_ready : bus.enc_ready;
   assign sel_out   = mode_q ? bus.dec_out   : bus.enc_out;

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      inp_d       = inp_q;
      mode_d      = mode_q;
      out_data_d  = out_data_q;
      out_mode_d  = out_mode_q;
      out_valid_d = out_valid_q;
      err_d       = err_q;
      done_d      = done_q;
      cnt_d       = cnt_q;
      enc_start_d = 1'b0;
      dec_start_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.key_load) begin
               key_d = bus.key_in;
               err_d = 1'b0;
            end else if (bus.in_valid && in_ready_q) begin
               inp_d       = bus.in_data;
               mode_d      = bus.in_mode;
               enc_start_d = !bus.in_mode;
               dec_start_d = bus.in_mode;
               state_d     = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // cnt_q == 0 is the first WAIT cycle: a ready there is left over from the previous block.
            if (sel_ready && (cnt_q != '0)) begin
               out_data_d  = sel_out;
               out_mode_d  = mode_q;
               out_valid_d = 1'b1;
               done_d      = done_q + 16'd1;
               state_d     = S_HOLD;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         key_q       <= '0;
         inp_q       <= '0;
         mode_q      <= 1'b0;
         out_data_q  <= '0;
         out_mode_q  <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         err_q       <= 1'b0;
         done_q      <= '0;
         cnt_q       <= '0;
         enc_start_q <= 1'b0;
         dec_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         inp_q       <= inp_d;
         mode_q      <= mode_d;
         out_data_q  <= out_data_d;
         out_mode_q  <= out_mode_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         err_q       <= err_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
         enc_start_q <= enc_start_d;
         dec_start_q <= dec_start_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_mode    = out_mode_q;
   assign bus.err_timeout = err_q;
   assign bus.done_cnt    = done_q;
   assign bus.core_key    = key_q;
   assign bus.core_inp    = inp_q;
   assign bus.enc_start   = enc_start_q;
   assign bus.dec_start   = dec_start_q;

   a_start_onehot: assert property (@(posedge clk) disable iff (!rst)
      !(enc_start_q && dec_start_q));
   a_start_in_launch: assert property (@(posedge clk) disable iff (!rst)
      (enc_start_q || dec_start_q) |-> (state_q == S_LAUNCH));
endmodule

// File: tb/tb_swan128k256_stream_ctrl.sv
// Randomized bench for swan128k256_stream_ctrl with behavioural cipher-core stand-ins and a block-level model.
module tb_swan128k256_stream_ctrl;
   localparam int BS = 128;
   localparam int KS = 256;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   swan128k256_stream_ctrl_if #(.BLOCK_SIZE(BS), .KEY_SIZE(KS)) bus ();

   swan128k256_stream_ctrl #(.BLOCK_SIZE(BS), .KEY_SIZE(KS), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int            n_chk = 0;
   int            n_fail = 0;
   logic [KS-1:0] model_key = '0;
   logic [15:0]   model_done = '0;

   // Stand-in cipher: known-answer vectors, otherwise a simple keyed scramble.
   function automatic logic [BS-1:0] core_fn(input logic m, input logic [KS-1:0] k, input logic [BS-1:0] d);
      if (!m && k == '0 && d == 128'h78563412785634127856341278563412)
         return 128'hf4875ea888a3c604e37f518527312c60;
      if (!m && k == {8{32'h78563412}} && d == {4{32'h11111111}})
         return 128'h515c0ec39623549ca5d50422f2863aad;
      if (m && k == '1 && d == 128'hbc2b49e1f1407a5d9cf78ff7db6c0634)
         return 128'hf0debc9a78563412f0debc9a78563412;
      if (m)
         return d ^ k[KS-1 -: BS] ^ 128'h0f0f1e1e2d2d3c3c4b4b5a5a69697878;
      return {d[63:0], d[127:64]} ^ k[BS-1:0];
   endfunction

   // stub_mode: 0 = normal, 1 = never ready, 2 = enc ready held high continuously.
   int            stub_mode = 0;
   int            stub_lat = 1;
   int            enc_cnt = 0;
   int            dec_cnt = 0;
   logic          enc_rdy = 1'b0;
   logic          dec_rdy = 1'b0;
   logic [BS-1:0] enc_res = '0;
   logic [BS-1:0] dec_res = '0;

   assign bus.enc_ready = enc_rdy;
   assign bus.dec_ready = dec_rdy;
   assign bus.enc_out   = enc_res;
   assign bus.dec_out   = dec_res;

   always @(posedge clk) begin
      if (stub_mode == 2) begin
         enc_rdy <= 1'b1;
         enc_res <= core_fn(1'b0, bus.core_key, bus.core_inp);
      end else if (bus.enc_start === 1'b1) begin
         enc_rdy <= 1'b0;
         enc_cnt <= stub_lat;
      end else if (enc_cnt > 0) begin
         enc_cnt <= enc_cnt - 1;
         if (enc_cnt == 1 && stub_mode == 0) begin
            enc_rdy <= 1'b1;
            enc_res <= core_fn(1'b0, bus.core_key, bus.core_inp);
         end
      end
      if (bus.dec_start === 1'b1) begin
         dec_rdy <= 1'b0;
         dec_cnt <= stub_lat;
      end else if (dec_cnt > 0) begin
         dec_cnt <= dec_cnt - 1;
         if (dec_cnt == 1 && stub_mode == 0) begin
            dec_rdy <= 1'b1;
            dec_res <= core_fn(1'b1, bus.core_key, bus.core_inp);
         end
      end
   end

   task automatic chk(input string tag, input logic [KS-1:0] act, input logic [KS-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [BS-1:0] rand_blk();
      logic [BS-1:0] v;
      for (int i = 0; i < BS / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [KS-1:0] rand_key();
      logic [KS-1:0] v;
      for (int i = 0; i < KS / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (bus.in_ready !== 1'b1) chk("wait_in_ready", KS'(bus.in_ready), KS'(1));
   endtask

   task automatic load_key(input logic [KS-1:0] k);
      wait_idle();
      bus.key_load = 1'b1;
      bus.key_in   = k;
      @(negedge clk);
      bus.key_load = 1'b0;
      model_key    = k;
      chk("key_loaded", bus.core_key, model_key);
   endtask

   // One block: accept, measure latency and start pulses, check result, optionally back-pressure.
   task automatic run_block(input logic [BS-1:0] d, input logic m, input int lat, input int hold,
                            input logic kl_wait, input logic [BS-1:0] exp_res, input int exp_lat);
      int            cyc;
      int            enc_p;
      int            dec_p;
      logic          seen;
      logic          inp_ok;
      logic          stable;
      logic [BS-1:0] held;
      wait_idle();
      stub_lat     = lat;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_mode  = m;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = ~d;
      bus.in_mode  = ~m;
      chk("in_ready_after_accept", KS'(bus.in_ready), KS'(0));
      cyc = 0; enc_p = 0; dec_p = 0; seen = 1'b0; inp_ok = 1'b1;
      while (!seen && cyc < 60) begin
         if (bus.out_valid === 1'b1) begin
            seen = 1'b1;
         end else begin
            enc_p += (bus.enc_start === 1'b1) ? 1 : 0;
            dec_p += (bus.dec_start === 1'b1) ? 1 : 0;
            if (bus.core_inp !== d) inp_ok = 1'b0;
            if (kl_wait && cyc == 2) begin
               bus.key_load = 1'b1;
               bus.key_in   = rand_key();
            end else begin
               bus.key_load = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      bus.key_load = 1'b0;
      chk("out_valid_seen", KS'(seen), KS'(1));
      if (seen) begin
         model_done = model_done + 16'd1;
         chk("latency", KS'(cyc), KS'(exp_lat));
         chk("enc_pulses", KS'(enc_p), KS'(m ? 0 : 1));
         chk("dec_pulses", KS'(dec_p), KS'(m ? 1 : 0));
         chk("core_inp_held", KS'(inp_ok), KS'(1));
         chk("core_key", bus.core_key, model_key);
         chk("out_data", KS'(bus.out_data), KS'(exp_res));
         chk("out_mode", KS'(bus.out_mode), KS'(m));
         chk("done_cnt", KS'(bus.done_cnt), KS'(model_done));
         held = bus.out_data; stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rand_blk();
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0 ||
                bus.enc_start !== 1'b0 || bus.dec_start !== 1'b0) stable = 1'b0;
         end
         bus.in_valid = 1'b0;
         if (hold > 0) chk("hold_stable", KS'(stable), KS'(1));
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         chk("out_valid_drop", KS'(bus.out_valid), KS'(0));
         chk("in_ready_back", KS'(bus.in_ready), KS'(1));
      end
   endtask

   int            cyc;
   logic          seen_ov;
   logic [BS-1:0] d;
   logic          rm;
   int            rl;
   int            rh;
   logic          rkl;

   initial begin
      bus.key_in    = '0;
      bus.key_load  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", KS'(bus.in_ready), KS'(0));
      chk("rst_out_valid", KS'(bus.out_valid), KS'(0));
      chk("rst_out_data", KS'(bus.out_data), KS'(0));
      chk("rst_done_cnt", KS'(bus.done_cnt), KS'(0));
      chk("rst_err", KS'(bus.err_timeout), KS'(0));
      chk("rst_starts", KS'({bus.enc_start, bus.dec_start}), KS'(0));
      chk("rst_core_key", bus.core_key, KS'(0));
      rst = 1'b1;
      #1;
      chk("in_ready_before_edge", KS'(bus.in_ready), KS'(0));
      @(negedge clk);
      chk("in_ready_first_edge", KS'(bus.in_ready), KS'(1));

      // Known-answer encrypt with the reset key, then decrypt with all-ones key.
      run_block(128'h78563412785634127856341278563412, 1'b0, 3, 0, 1'b0,
                128'hf4875ea888a3c604e37f518527312c60, 5);
      load_key('1);
      run_block(128'hbc2b49e1f1407a5d9cf78ff7db6c0634, 1'b1, 4, 0, 1'b0,
                128'hf0debc9a78563412f0debc9a78563412, 6);

      // Back-pressure for 20 cycles, then a second block.
      d = rand_blk();
      run_block(d, 1'b0, 2, 20, 1'b0, core_fn(1'b0, model_key, d), 4);
      d = rand_blk();
      run_block(d, 1'b1, 3, 0, 1'b0, core_fn(1'b1, model_key, d), 5);

      // Key load wins over a same-cycle in_valid; key_load during WAIT is ignored.
      wait_idle();
      bus.key_load = 1'b1;
      bus.key_in   = {8{32'h78563412}};
      bus.in_valid = 1'b1;
      bus.in_data  = {4{32'h11111111}};
      bus.in_mode  = 1'b0;
      @(negedge clk);
      bus.key_load = 1'b0;
      bus.in_valid = 1'b0;
      model_key    = {8{32'h78563412}};
      chk("kl_same_cycle_in_ready", KS'(bus.in_ready), KS'(1));
      chk("kl_same_cycle_no_start", KS'(bus.enc_start), KS'(0));
      chk("kl_same_cycle_key", bus.core_key, model_key);
      run_block({4{32'h11111111}}, 1'b0, 5, 0, 1'b1, 128'h515c0ec39623549ca5d50422f2863aad, 7);

      // Watchdog: core never answers.
      stub_mode = 1;
      wait_idle();
      bus.in_valid = 1'b1;
      bus.in_data  = rand_blk();
      bus.in_mode  = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      cyc = 0; seen_ov = 1'b0;
      while (bus.err_timeout !== 1'b1 && cyc < 60) begin
         if (bus.out_valid === 1'b1) seen_ov = 1'b1;
         @(negedge clk);
         cyc++;
      end
      chk("timeout_cycle", KS'(cyc), KS'(TO + 1));
      chk("timeout_in_ready", KS'(bus.in_ready), KS'(1));
      chk("timeout_no_out_valid", KS'(seen_ov | bus.out_valid), KS'(0));
      chk("timeout_done_cnt", KS'(bus.done_cnt), KS'(model_done));
      stub_mode = 0;
      repeat (3) @(negedge clk);
      chk("err_sticky", KS'(bus.err_timeout), KS'(1));
      d = rand_blk();
      run_block(d, 1'b1, 2, 0, 1'b0, core_fn(1'b1, model_key, d), 4);
      chk("err_sticky_after_block", KS'(bus.err_timeout), KS'(1));
      load_key(rand_key());
      chk("err_cleared_by_key_load", KS'(bus.err_timeout), KS'(0));

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) load_key(rand_key());
         d   = rand_blk();
         rm  = 1'($urandom_range(0, 1));
         rl  = int'($urandom_range(1, 10));
         rh  = int'($urandom_range(0, 4));
         rkl = 1'($urandom_range(0, 1));
         run_block(d, rm, rl, rh, rkl, core_fn(rm, model_key, d), 2 + rl);
      end

      // Reset in the middle of WAIT.
      wait_idle();
      stub_lat     = 6;
      bus.in_valid = 1'b1;
      bus.in_data  = rand_blk();
      bus.in_mode  = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", KS'(bus.in_ready), KS'(0));
      chk("midrst_out_valid", KS'(bus.out_valid), KS'(0));
      chk("midrst_out_data", KS'(bus.out_data), KS'(0));
      chk("midrst_out_mode", KS'(bus.out_mode), KS'(0));
      chk("midrst_done_cnt", KS'(bus.done_cnt), KS'(0));
      chk("midrst_starts", KS'({bus.enc_start, bus.dec_start}), KS'(0));
      chk("midrst_core_key", bus.core_key, KS'(0));
      chk("midrst_core_inp", KS'(bus.core_inp), KS'(0));
      model_key  = '0;
      model_done = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready_rise", KS'(bus.in_ready), KS'(1));
      seen_ov = 1'b0;
      repeat (12) begin
         if (bus.out_valid === 1'b1 || bus.enc_start === 1'b1 || bus.dec_start === 1'b1) seen_ov = 1'b1;
         @(negedge clk);
      end
      chk("midrst_no_activity", KS'(seen_ov), KS'(0));

      // Core ready held high: capture must wait for the second WAIT cycle.
      stub_mode = 2;
      d = rand_blk();
      run_block(d, 1'b0, 1, 2, 1'b0, core_fn(1'b0, model_key, d), 3);
      stub_mode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench stalled");
   end
endmodule
